frame_buffer_ctrl: RTL and testbench
====================================

FRAME_BUFFER_CTRL -- requirements
Module: frame_buffer_ctrl

Interface
REQ-001 SHALL have parameter SCREEN_WIDTH, default 320, meaning the ray-frame width in pixels.
REQ-002 SHALL have parameter SCREEN_HEIGHT, default 180, meaning the ray-frame height in pixels.
REQ-003 SHALL have parameter PIXEL_WIDTH, default 16, meaning the bits per pixel (RGB565).
REQ-004 SHALL have port pixel_clk_in, input, 1 bit, the single clock for all logic.
REQ-005 SHALL have port rst_in, input, 1 bit; reset is asynchronous and active-high.
REQ-006 SHALL have port ray_valid_in, input, 1 bit, meaning a pixel write is offered by the transformation stage.
REQ-007 SHALL have port ray_address_in, input, 16 bits, meaning the linear pixel address (hcount + vcount*SCREEN_WIDTH).
REQ-008 SHALL have port ray_pixel_in, input, PIXEL_WIDTH bits, meaning the pixel value.
REQ-009 SHALL have port ray_last_pixel_in, input, 1 bit, meaning the offered pixel is the final pixel of the frame.
REQ-010 SHALL have port ray_ready_out, output, 1 bit, meaning the block accepts a pixel this cycle.
REQ-011 SHALL have port frame_start_in, input, 1 bit, a single-cycle pulse from display timing at the start of each display frame.
REQ-012 SHALL have port bram_wr_en_out, output, 1 bit, the dual-BRAM write enable.
REQ-013 SHALL have port bram_wr_addr_out, output, 17 bits; bit 16 is the buffer select and bits 15:0 are the pixel address.
REQ-014 SHALL have port bram_wr_data_out, output, PIXEL_WIDTH bits, the write data.
REQ-015 SHALL have port rd_buf_sel_out, output, 1 bit, meaning the buffer the display reads (the front buffer).
REQ-016 SHALL have port swap_out, output, 1 bit, a one-cycle pulse on each buffer swap.
REQ-017 SHALL have port frame_count_out, output, 8 bits, meaning completed swaps modulo 256.
REQ-018 SHALL have port addr_err_out, output, 1 bit, a sticky flag for an out-of-range address.
REQ-019 SHALL have port short_frame_err_out, output, 1 bit, a sticky flag for a frame that closed with the wrong pixel count.

Function
REQ-020 SHALL implement states WRITING, WAIT_SWAP and SWAP.
REQ-021 SHALL drive ray_ready_out combinationally: 1 in WRITING, 0 in WAIT_SWAP and SWAP.
REQ-022 SHALL treat accept as ray_valid_in AND ray_ready_out; no other input has effect on the write path.
REQ-023 SHALL, on an accept in cycle n, assert bram_wr_en_out in cycle n+1 with bram_wr_addr_out = {~rd_buf_sel_out, ray_address_in} and bram_wr_data_out = ray_pixel_in, all registered (1-cycle latency); bram_wr_en_out SHALL be 0 in any cycle not following an accept.
REQ-024 SHALL hold bram_wr_addr_out and bram_wr_data_out at their last values when bram_wr_en_out=0.
REQ-025 SHALL, when an accepted address is >= SCREEN_WIDTH*SCREEN_HEIGHT (57600), suppress that write (bram_wr_en_out=0 in n+1) and set addr_err_out to 1 until reset.
REQ-026 SHALL count accepted pixels (16-bit counter, out-of-range pixels included) and clear the counter when the frame closes.
REQ-027 SHALL close the frame on an accept with ray_last_pixel_in=1: WRITING -> WAIT_SWAP.
REQ-028 SHALL, at frame close, set short_frame_err_out (sticky) if the count including the last pixel is not equal to 57600.
REQ-029 SHALL, in WAIT_SWAP, move to SWAP in the cycle after frame_start_in=1 is sampled.
REQ-030 SHALL ignore frame_start_in in WRITING and SWAP, including when it coincides with the closing accept; the swap then waits for the next pulse.
REQ-031 SHALL, in SWAP (exactly one cycle), toggle rd_buf_sel_out, pulse swap_out=1, increment frame_count_out (255 wraps to 0), and return to WRITING.
REQ-032 SHALL ensure the write buffer is always ~rd_buf_sel_out, so the displayed buffer is never written.
REQ-033 SHALL let the last pixel's write (cycle n+1) complete before or while the state is WAIT_SWAP; no write SHALL target the new back buffer before the SWAP cycle.

Reset
REQ-034 SHALL, while rst_in=1 (asynchronously), force: state WRITING; rd_buf_sel_out 0; bram_wr_en_out 0; bram_wr_addr_out 0; bram_wr_data_out 0; swap_out 0; frame_count_out 0; addr_err_out 0; short_frame_err_out 0; pixel counter 0.
REQ-035 SHALL, on reset mid-frame, discard all partial-frame progress and accept pixels from the first clock edge after deassertion.

Verification
REQ-036 Basic write: reset, then an accept with addr=100, pixel=16'hF800 -> next cycle wr_en=1, wr_addr=17'h10064, wr_data=16'hF800.
REQ-037 Full frame: 57600 accepts (addr 0..57599), last flagged, frame_start pulse 10 cycles later -> ready=0 during the wait, SWAP one cycle after the pulse, rd_buf_sel=1, swap_out one pulse, frame_count=1, both error flags 0, next write at wr_addr bit16=0.
REQ-038 Range check: accept addr=57600 -> wr_en stays 0 next cycle, addr_err=1 persists; short frame of 100 pixels with last -> short_frame_err=1.
REQ-039 Coincidence: frame_start_in in the same cycle as the last-pixel accept -> no swap; swap occurs on the following frame_start pulse.
REQ-040 Wrap and reset: 256 frames -> frame_count=0, rd_buf_sel=0; rst_in asserted mid-frame asynchronously -> outputs at reset values before the next clock edge, ready=1 after release.

Source files
------------

// File: rtl/frame_buffer_ctrl.sv
// frame_buffer_ctrl
// Double-buffered frame store controller. Pixels from the transformation
// stage are written into the back buffer of a dual-BRAM frame store while the
// display scans the front buffer. Once a frame closes (last-pixel accept), the
// controller waits for the next display frame_start pulse. It then swaps
// buffers for exactly one cycle and resumes writing.
//
// Ports
//   pixel_clk_in        : single clock for all logic
//   rst_in              : asynchronous active-high reset
//   ray_valid_in        : pixel write offered
//   ray_address_in      : linear pixel address (hcount + vcount*SCREEN_WIDTH)
//   ray_pixel_in        : pixel value
//   ray_last_pixel_in   : offered pixel is the final pixel of the frame
//   ray_ready_out       : pixel accepted this cycle (combinational, WRITING)
//   frame_start_in      : display frame start pulse
//   bram_wr_en_out      : BRAM write enable (registered)
//   bram_wr_addr_out    : {buffer select, pixel address} (registered)
//   bram_wr_data_out    : BRAM write data (registered)
//   rd_buf_sel_out      : buffer currently read by the display
//   swap_out            : one-cycle pulse during the swap cycle
//   frame_count_out     : completed swaps modulo 256
//   addr_err_out        : sticky, an out-of-range address was accepted
//   short_frame_err_out : sticky, a frame closed with the wrong pixel count
module frame_buffer_ctrl #(
    parameter int SCREEN_WIDTH  = 320,
    parameter int SCREEN_HEIGHT = 180,
    parameter int PIXEL_WIDTH   = 16
) (
    input  logic                   pixel_clk_in,
    input  logic                   rst_in,
    input  logic                   ray_valid_in,
    input  logic [15:0]            ray_address_in,
    input  logic [PIXEL_WIDTH-1:0] ray_pixel_in,
    input  logic                   ray_last_pixel_in,
    output logic                   ray_ready_out,
    input  logic                   frame_start_in,
    output logic                   bram_wr_en_out,
    output logic [16:0]            bram_wr_addr_out,
    output logic [PIXEL_WIDTH-1:0] bram_wr_data_out,
    output logic                   rd_buf_sel_out,
    output logic                   swap_out,
    output logic [7:0]             frame_count_out,
    output logic                   addr_err_out,
    output logic                   short_frame_err_out
);

    localparam int          FRAME_PIXELS = SCREEN_WIDTH * SCREEN_HEIGHT;
    localparam logic [16:0] FRAME_LIMIT  = 17'(FRAME_PIXELS);
    localparam logic [15:0] FRAME_COUNT  = 16'(FRAME_PIXELS);

    typedef enum logic [1:0] {
        WRITING   = 2'd0,
        WAIT_SWAP = 2'd1,
        SWAP      = 2'd2
    } state_t;

    state_t                 state_q, state_d;
    logic                   rd_buf_sel_q, rd_buf_sel_d;
    logic                   wr_en_q, wr_en_d;
    logic [16:0]            wr_addr_q, wr_addr_d;
    logic [PIXEL_WIDTH-1:0] wr_data_q, wr_data_d;
    logic                   swap_q, swap_d;
    logic [7:0]             frame_count_q, frame_count_d;
    logic                   addr_err_q, addr_err_d;
    logic                   short_err_q, short_err_d;
    logic [15:0]            pix_cnt_q, pix_cnt_d;

    logic        accept;
    logic        in_range;
    logic [15:0] pix_cnt_inc;

    assign ray_ready_out = (state_q == WRITING);
    assign accept        = ray_valid_in & ray_ready_out;
    assign in_range      = ({1'b0, ray_address_in} < FRAME_LIMIT);
    assign pix_cnt_inc   = pix_cnt_q + 16'd1;

    always_comb begin
        state_d       = state_q;
        rd_buf_sel_d  = rd_buf_sel_q;
        wr_en_d       = 1'b0;
        wr_addr_d     = wr_addr_q;
        wr_data_d     = wr_data_q;
        swap_d        = 1'b0;
        frame_count_d = frame_count_q;
        addr_err_d    = addr_err_q;
        short_err_d   = short_err_q;
        pix_cnt_d     = pix_cnt_q;

        // Write path: address and data only move on a real write, so they
        // hold through idle cycles and suppressed out-of-range accepts.
        if (accept) begin
            if (in_range) begin
                wr_en_d   = 1'b1;
                wr_addr_d = {~rd_buf_sel_q, ray_address_in};
                wr_data_d = ray_pixel_in;
            end else begin
                addr_err_d = 1'b1;
            end
        end

        case (state_q)
            WRITING: begin
                if (accept) begin
                    if (ray_last_pixel_in) begin
                        if (pix_cnt_inc != FRAME_COUNT) begin
                            short_err_d = 1'b1;
                        end
                        pix_cnt_d = 16'd0;
                        state_d   = WAIT_SWAP;
                    end else begin
                        pix_cnt_d = pix_cnt_inc;
                    end
                end
            end
            WAIT_SWAP: begin
                // Swap-cycle outputs are set on entry so they are visible
                // for the whole SWAP cycle.
                if (frame_start_in) begin
                    state_d       = SWAP;
                    rd_buf_sel_d  = ~rd_buf_sel_q;
                    swap_d        = 1'b1;
                    frame_count_d = frame_count_q + 8'd1;
                end
            end
            SWAP: begin
                state_d = WRITING;
            end
            default: begin
                state_d = WRITING;
            end
        endcase
    end

    always_ff @(posedge pixel_clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q       <= WRITING;
            rd_buf_sel_q  <= 1'b0;
            wr_en_q       <= 1'b0;
            wr_addr_q     <= '0;
            wr_data_q     <= '0;
            swap_q        <= 1'b0;
            frame_count_q <= 8'd0;
            addr_err_q    <= 1'b0;
            short_err_q   <= 1'b0;
            pix_cnt_q     <= 16'd0;
        end else begin
            state_q       <= state_d;
            rd_buf_sel_q  <= rd_buf_sel_d;
            wr_en_q       <= wr_en_d;
            wr_addr_q     <= wr_addr_d;
            wr_data_q     <= wr_data_d;
            swap_q        <= swap_d;
            frame_count_q <= frame_count_d;
            addr_err_q    <= addr_err_d;
            short_err_q   <= short_err_d;
            pix_cnt_q     <= pix_cnt_d;
        end
    end

    assign bram_wr_en_out      = wr_en_q;
    assign bram_wr_addr_out    = wr_addr_q;
    assign bram_wr_data_out    = wr_data_q;
    assign rd_buf_sel_out      = rd_buf_sel_q;
    assign swap_out            = swap_q;
    assign frame_count_out     = frame_count_q;
    assign addr_err_out        = addr_err_q;
    assign short_frame_err_out = short_err_q;

endmodule

// File: tb/tb_frame_buffer_ctrl.sv
// Testbench for frame_buffer_ctrl: directed scenarios plus randomized traffic,
// all checked cycle by cycle against a behavioural reference model.
module tb_frame_buffer_ctrl;

    localparam int NPIX = 57600;

    logic        clk = 1'b0;
    logic        rst_in = 1'b0;
    logic        ray_valid_in = 1'b0;
    logic [15:0] ray_address_in = '0;
    logic [15:0] ray_pixel_in = '0;
    logic        ray_last_pixel_in = 1'b0;
    logic        frame_start_in = 1'b0;
    logic        ray_ready_out;
    logic        bram_wr_en_out;
    logic [16:0] bram_wr_addr_out;
    logic [15:0] bram_wr_data_out;
    logic        rd_buf_sel_out;
    logic        swap_out;
    logic [7:0]  frame_count_out;
    logic        addr_err_out;
    logic        short_frame_err_out;

    int n_vec = 0;
    int n_err = 0;

    // Reference model: mode 0 = accepting pixels, 1 = frame closed and
    // waiting for display start, 2 = the single swap cycle.
    int          m_mode;
    int          m_cnt;
    int          m_fc;
    logic        m_sel, m_wen, m_swap, m_aerr, m_serr;
    logic [16:0] m_waddr;
    logic [15:0] m_wdata;

    always #5 clk = ~clk;

    frame_buffer_ctrl dut (
        .pixel_clk_in        (clk),
        .rst_in              (rst_in),
        .ray_valid_in        (ray_valid_in),
        .ray_address_in      (ray_address_in),
        .ray_pixel_in        (ray_pixel_in),
        .ray_last_pixel_in   (ray_last_pixel_in),
        .ray_ready_out       (ray_ready_out),
        .frame_start_in      (frame_start_in),
        .bram_wr_en_out      (bram_wr_en_out),
        .bram_wr_addr_out    (bram_wr_addr_out),
        .bram_wr_data_out    (bram_wr_data_out),
        .rd_buf_sel_out      (rd_buf_sel_out),
        .swap_out            (swap_out),
        .frame_count_out     (frame_count_out),
        .addr_err_out        (addr_err_out),
        .short_frame_err_out (short_frame_err_out)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_mode = 0; m_cnt = 0; m_fc = 0;
        m_sel = 0; m_wen = 0; m_swap = 0; m_aerr = 0; m_serr = 0;
        m_waddr = '0; m_wdata = '0;
    endtask

    task automatic check_outputs();
        check_eq("wr_en",     32'(bram_wr_en_out),      32'(m_wen));
        check_eq("wr_addr",   32'(bram_wr_addr_out),    32'(m_waddr));
        check_eq("wr_data",   32'(bram_wr_data_out),    32'(m_wdata));
        check_eq("rd_sel",    32'(rd_buf_sel_out),      32'(m_sel));
        check_eq("swap",      32'(swap_out),            32'(m_swap));
        check_eq("frame_cnt", 32'(frame_count_out),     32'(m_fc));
        check_eq("addr_err",  32'(addr_err_out),        32'(m_aerr));
        check_eq("short_err", 32'(short_frame_err_out), 32'(m_serr));
    endtask

    // One clock: drive inputs at the falling edge, advance the model by the
    // specification's rules, then compare registered outputs after the edge.
    task automatic step(input logic v, input logic [15:0] a, input logic [15:0] p,
                        input logic l, input logic fs);
        logic acc;
        @(negedge clk);
        ray_valid_in = v; ray_address_in = a; ray_pixel_in = p;
        ray_last_pixel_in = l; frame_start_in = fs;
        check_eq("ready", 32'(ray_ready_out), 32'(m_mode == 0));
        acc = v && (m_mode == 0);
        m_swap = 0;
        m_wen = acc && (a < NPIX);
        if (m_wen) begin
            m_waddr = {~m_sel, a};
            m_wdata = p;
        end
        if (m_mode == 0) begin
            if (acc) begin
                m_cnt++;
                if (a >= NPIX) m_aerr = 1;
                if (l) begin
                    if (m_cnt != NPIX) m_serr = 1;
                    m_cnt = 0;
                    m_mode = 1;
                end
            end
        end else if (m_mode == 1) begin
            if (fs) begin
                m_mode = 2;
                m_sel = ~m_sel;
                m_fc = (m_fc + 1) % 256;
                m_swap = 1;
            end
        end else begin
            m_mode = 0;
        end
        @(posedge clk);
        #1;
        check_outputs();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 16'h0, 16'h0, 0, 0);
    endtask

    // Assert reset away from a clock edge; outputs must clear at once.
    task automatic apply_reset();
        @(negedge clk);
        #2;
        rst_in = 1'b1;
        ray_valid_in = 0; ray_last_pixel_in = 0; frame_start_in = 0;
        #1;
        model_reset();
        check_eq("rst_ready", 32'(ray_ready_out), 32'd1);
        check_outputs();
        @(negedge clk);
        rst_in = 1'b0;
    endtask

    initial begin
        model_reset();
        #2;
        rst_in = 1'b1;
        #1;
        check_eq("init_ready", 32'(ray_ready_out), 32'd1);
        check_outputs();
        @(negedge clk);
        @(negedge clk);
        rst_in = 1'b0;

        // Basic write
        step(1, 16'd100, 16'hF800, 0, 0);
        check_eq("basic_en",   32'(bram_wr_en_out),   32'd1);
        check_eq("basic_addr", 32'(bram_wr_addr_out), 32'h10064);
        check_eq("basic_data", 32'(bram_wr_data_out), 32'hF800);
        idle(1);
        check_eq("basic_hold", 32'(bram_wr_addr_out), 32'h10064);

        // Full frame, swap 10 cycles after close
        apply_reset();
        for (int i = 0; i < NPIX; i++)
            step(1, 16'(i), 16'($urandom), i == NPIX - 1, 0);
        for (int i = 0; i < 10; i++) begin
            step(0, 16'h0, 16'h0, 0, 0);
            check_eq("wait_ready", 32'(ray_ready_out), 32'd0);
        end
        step(0, 16'h0, 16'h0, 0, 1);
        check_eq("ff_swap",  32'(swap_out),        32'd1);
        check_eq("ff_sel",   32'(rd_buf_sel_out),  32'd1);
        check_eq("ff_count", 32'(frame_count_out), 32'd1);
        idle(1);
        check_eq("ff_swap_gone", 32'(swap_out), 32'd0);
        step(1, 16'd5, 16'h1234, 0, 0);
        check_eq("ff_next_bank", 32'(bram_wr_addr_out), 32'h00005);
        check_eq("ff_aerr",  32'(addr_err_out),        32'd0);
        check_eq("ff_serr",  32'(short_frame_err_out), 32'd0);

        // Range check, then short frame of 100 pixels
        apply_reset();
        step(1, 16'd57600, 16'hAAAA, 0, 0);
        check_eq("range_en",   32'(bram_wr_en_out), 32'd0);
        check_eq("range_aerr", 32'(addr_err_out),   32'd1);
        apply_reset();
        for (int i = 0; i < 100; i++) step(1, 16'(i), 16'($urandom), i == 99, 0);
        check_eq("short_serr", 32'(short_frame_err_out), 32'd1);
        idle(3);
        step(0, 16'h0, 16'h0, 0, 1);
        idle(1);

        // Coincident frame_start with last-pixel accept
        step(1, 16'd7, 16'h0F0F, 1, 1);
        idle(4);
        check_eq("coin_noswap", 32'(frame_count_out), 32'd1);
        step(0, 16'h0, 16'h0, 0, 1);
        check_eq("coin_swap", 32'(swap_out), 32'd1);
        idle(1);

        // Randomized traffic
        for (int i = 0; i < 1500; i++) begin
            logic [15:0] a;
            a = ($urandom_range(0, 15) == 0) ? 16'($urandom_range(NPIX, 65535))
                                             : 16'($urandom_range(0, NPIX - 1));
            step($urandom_range(0, 3) != 0, a, 16'($urandom),
                 $urandom_range(0, 63) == 0, $urandom_range(0, 7) == 0);
        end

        // Frame counter wrap
        apply_reset();
        for (int f = 0; f < 256; f++) begin
            step(1, 16'(f), 16'(f), 1, 0);
            step(0, 16'h0, 16'h0, 0, 1);
            step(0, 16'h0, 16'h0, 0, $urandom_range(0, 1) == 1);
        end
        check_eq("wrap_count", 32'(frame_count_out), 32'd0);
        check_eq("wrap_sel",   32'(rd_buf_sel_out),  32'd0);

        // Mid-frame asynchronous reset
        for (int i = 0; i < 20; i++) step(1, 16'(i), 16'($urandom), 0, 0);
        step(0, 16'h0, 16'h0, 0, 1);
        step(0, 16'h0, 16'h0, 0, 1);
        step(0, 16'h0, 16'h0, 0, 1);
        apply_reset();
        check_eq("post_rst_ready", 32'(ray_ready_out), 32'd1);
        step(1, 16'd200, 16'h07E0, 0, 0);
        check_eq("post_rst_en",   32'(bram_wr_en_out),   32'd1);
        check_eq("post_rst_addr", 32'(bram_wr_addr_out), 32'h100C8);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
